// File: rtl/diag_fault_map_collector_if.sv
// ----------------------------------------------------------------------------
// diag_fault_map_collector_if
//   Bundles the control, per-row fault input and fault-map result signals of
//   diag_fault_map_collector.
//   master : the self-test sequencer / eNVM writer side
//            (drives start, abort and col_inputs)
//   slave  : the collector (drives row_idx, status, maps and fault_count)
// Signals:
//   start, abort            pass control
//   col_inputs   [COLS]     fault bit per PE of the row addressed by row_idx
//   row_idx      [ADDR]     row being sampled this cycle
//   busy, done              pass status
//   single_pe_detection     registered copy of the last sampled row
//   single_pe_valid         single_pe_detection updated at the last edge
//   row_fault_detection     sticky row fault map
//   column_fault_detection  sticky column fault map
//   fault_count             total faulty PEs in the current pass
// ----------------------------------------------------------------------------
interface diag_fault_map_collector_if #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_WIDTH = $clog2(ROWS)
);
  localparam int CNT_W = $clog2(ROWS * COLS + 1);

  logic                  start;
  logic                  abort;
  logic [COLS-1:0]       col_inputs;
  logic [ADDR_WIDTH-1:0] row_idx;
  logic                  busy;
  logic                  done;
  logic [COLS-1:0]       single_pe_detection;
  logic                  single_pe_valid;
  logic [ROWS-1:0]       row_fault_detection;
  logic [COLS-1:0]       column_fault_detection;
  logic [CNT_W-1:0]      fault_count;

  modport master (
    output start, abort, col_inputs,
    input  row_idx, busy, done, single_pe_detection, single_pe_valid,
           row_fault_detection, column_fault_detection, fault_count
  );

  modport slave (
    input  start, abort, col_inputs,
    output row_idx, busy, done, single_pe_detection, single_pe_valid,
           row_fault_detection, column_fault_detection, fault_count
  );
endinterface

// File: rtl/diag_fault_map_collector.sv
// ----------------------------------------------------------------------------
// diag_fault_map_collector
//   Scans a ROWS x COLS systolic array one row per cycle and folds the per-PE
//   fault bits into sticky row and column fault maps plus a total fault count.
//   row_idx addresses the eNVM fault record of the row being captured.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    diag_fault_map_collector_if.slave (see interface header)
//
// Build option:
//   DIAG_CONSECUTIVE_EN defined   : row metric = longest run of adjacent faulty
//                                   columns; column counters count consecutive
//                                   faulty rows (reset on a clean row).
//   DIAG_CONSECUTIVE_EN undefined : row metric = popcount of the row; column
//                                   counters accumulate over the whole pass.
// ----------------------------------------------------------------------------
module diag_fault_map_collector #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ROW_THRESH = 3,
  parameter int COL_THRESH = 3,
  parameter int ADDR_WIDTH = $clog2(ROWS)
) (
  input logic                        clk,
  input logic                        rst_n,
  diag_fault_map_collector_if.slave  bus
);

  localparam int CNT_W = $clog2(ROWS * COLS + 1);  // fault_count width
  localparam int CC_W  = $clog2(ROWS + 1);         // per-column counter width
  localparam int PC_W  = $clog2(COLS + 1);         // row metric width

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW     = ADDR_WIDTH'(ROWS - 1);
  localparam logic [CC_W-1:0]       COL_SAT      = CC_W'(ROWS);
  localparam logic [CC_W-1:0]       COL_THRESH_C = CC_W'(COL_THRESH);
  localparam logic [PC_W-1:0]       ROW_THRESH_C = PC_W'(ROW_THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  clear;     // accepted start: wipe the pass results
  logic                  sample;    // capture col_inputs as row row_idx_q
  logic                  rewind;    // abort in SCAN: park row_idx at 0

  logic [ADDR_WIDTH-1:0] row_idx_q;
  logic [COLS-1:0]       single_pe_q;
  logic                  single_valid_q;
  logic [ROWS-1:0]       row_map_q;
  logic [COLS-1:0]       col_map_q;
  logic [CNT_W-1:0]      fault_count_q;
  logic [CC_W-1:0]       col_cnt_q   [COLS];
  logic [CC_W-1:0]       col_cnt_nxt [COLS];
  logic [COLS-1:0]       col_hit;
  logic [PC_W-1:0]       row_pop;
  logic [PC_W-1:0]       row_metric;
  logic                  row_hit;

  function automatic logic [PC_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

`ifdef DIAG_CONSECUTIVE_EN
  function automatic logic [PC_W-1:0] longest_run(input logic [COLS-1:0] v);
    logic [PC_W-1:0] run;
    logic [PC_W-1:0] best;
    run  = '0;
    best = '0;
    for (int i = 0; i < COLS; i++) begin
      run = v[i] ? run + PC_W'(1) : '0;
      if (run > best) best = run;
    end
    return best;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    sample  = 1'b0;
    rewind  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SCAN;
          clear   = 1'b1;
        end
      end
      SCAN: begin
        // abort wins over both start and the sample of this cycle
        if (bus.abort) begin
          state_d = IDLE;
          rewind  = 1'b1;
        end else begin
          sample = 1'b1;
          if (row_idx_q == LAST_ROW) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Row and column metrics for the row on col_inputs this cycle
  // --------------------------------------------------------------------------
  always_comb begin
    row_pop = popcount(bus.col_inputs);
`ifdef DIAG_CONSECUTIVE_EN
    row_metric = longest_run(bus.col_inputs);
`else
    row_metric = row_pop;
`endif
    row_hit = (row_metric >= ROW_THRESH_C);

    col_hit = '0;
    for (int c = 0; c < COLS; c++) begin
      if (bus.col_inputs[c]) begin
        col_cnt_nxt[c] = (col_cnt_q[c] == COL_SAT) ? COL_SAT
                                                   : col_cnt_q[c] + CC_W'(1);
      end else begin
`ifdef DIAG_CONSECUTIVE_EN
        col_cnt_nxt[c] = '0;
`else
        col_cnt_nxt[c] = col_cnt_q[c];
`endif
      end
      // flag on the updated count so it lands together with the counter
      col_hit[c] = (col_cnt_nxt[c] >= COL_THRESH_C);
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      row_idx_q      <= '0;
      single_pe_q    <= '0;
      single_valid_q <= 1'b0;
      row_map_q      <= '0;
      col_map_q      <= '0;
      fault_count_q  <= '0;
      // NOTE: the column counters are reset (not left as uninitialised
      // storage) because they feed the map flags directly.
      col_cnt_q      <= '{default: '0};
    end else begin
      state_q        <= state_d;
      single_valid_q <= sample;
      if (clear) begin
        row_idx_q     <= '0;
        row_map_q     <= '0;
        col_map_q     <= '0;
        fault_count_q <= '0;
        col_cnt_q     <= '{default: '0};
      end else if (sample) begin
        single_pe_q   <= bus.col_inputs;
        // bounded by ROWS*COLS, which CNT_W holds, so it cannot wrap
        fault_count_q <= fault_count_q + CNT_W'(row_pop);
        if (row_hit) row_map_q[row_idx_q] <= 1'b1;
        col_map_q     <= col_map_q | col_hit;
        col_cnt_q     <= col_cnt_nxt;
        row_idx_q     <= (row_idx_q == LAST_ROW) ? '0 : row_idx_q + ADDR_WIDTH'(1);
      end else if (rewind) begin
        row_idx_q <= '0;
      end
    end
  end

  assign bus.row_idx                = row_idx_q;
  assign bus.busy                   = (state_q == SCAN);
  assign bus.done                   = (state_q == DONE);
  assign bus.single_pe_detection    = single_pe_q;
  assign bus.single_pe_valid        = single_valid_q;
  assign bus.row_fault_detection    = row_map_q;
  assign bus.column_fault_detection = col_map_q;
  assign bus.fault_count            = fault_count_q;

endmodule

// File: tb/tb_diag_fault_map_collector.sv
// ----------------------------------------------------------------------------
// tb_diag_fault_map_collector
//   Self-checking bench for diag_fault_map_collector (ROWS=COLS=8, thresholds
//   3). Each row driven during a pass pushes its expected registered results
//   to a scoreboard queue; a negedge monitor pops and compares whenever
//   single_pe_valid is high. End-of-pass maps are also compared against fixed
//   constants for each scenario. Works for either DIAG_CONSECUTIVE_EN build.
// ----------------------------------------------------------------------------
module tb_diag_fault_map_collector;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int ROW_TH = 3;
  localparam int COL_TH = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  diag_fault_map_collector_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  diag_fault_map_collector #(
    .ROWS(ROWS), .COLS(COLS), .ROW_THRESH(ROW_TH), .COL_THRESH(COL_TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] det;
    int         fc;
    logic [7:0] rmap;
    logic [7:0] cmap;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_rmap, m_cmap;
  int         m_fc, m_row;
  int         m_cnt[COLS];
  logic [7:0] pat[ROWS];

  task automatic model_clear();
    m_rmap = '0;
    m_cmap = '0;
    m_fc   = 0;
    m_row  = 0;
    foreach (m_cnt[c]) m_cnt[c] = 0;
  endtask

  task automatic model_row(input logic [7:0] v);
    exp_t       e;
    logic [7:0] mask;
    mask = 8'((1 << ROW_TH) - 1);
    m_fc += $countones(v);
`ifdef DIAG_CONSECUTIVE_EN
    // a run of ROW_TH adjacent faults exists if any aligned window is all ones
    for (int s = 0; s <= COLS - ROW_TH; s++)
      if (((v >> s) & mask) == mask) m_rmap[m_row] = 1'b1;
`else
    if ($countones(v) >= ROW_TH) m_rmap[m_row] = 1'b1;
`endif
    for (int c = 0; c < COLS; c++) begin
      if (v[c]) m_cnt[c]++;
`ifdef DIAG_CONSECUTIVE_EN
      else m_cnt[c] = 0;
`endif
      if (m_cnt[c] >= COL_TH) m_cmap[c] = 1'b1;
    end
    e.det  = v;
    e.fc   = m_fc;
    e.rmap = m_rmap;
    e.cmap = m_cmap;
    sb_q.push_back(e);
    m_row++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.single_pe_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_single_pe", bus.single_pe_detection, e.det);
        check("sb_fault_count", bus.fault_count, e.fc);
        check("sb_row_map", bus.row_fault_detection, e.rmap);
        check("sb_col_map", bus.column_fault_detection, e.cmap);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row_idx"}, bus.row_idx, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_valid"}, bus.single_pe_valid, 0);
    check({tag, "_single"}, bus.single_pe_detection, 0);
    check({tag, "_rmap"}, bus.row_fault_detection, 0);
    check({tag, "_cmap"}, bus.column_fault_detection, 0);
    check({tag, "_fc"}, bus.fault_count, 0);
  endtask

  // Full pass over pat[]; start_at >= 0 re-asserts start on that row.
  task automatic scan_pass(input int start_at);
    model_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("entry_busy", bus.busy, 1);
    check("entry_done", bus.done, 0);
    check("entry_fc", bus.fault_count, 0);
    check("entry_rmap", bus.row_fault_detection, 0);
    check("entry_cmap", bus.column_fault_detection, 0);
    check("entry_valid", bus.single_pe_valid, 0);
    for (int k = 0; k < ROWS; k++) begin
      check("scan_row_idx", bus.row_idx, k);
      check("scan_busy", bus.busy, 1);
      check("scan_done", bus.done, 0);
      bus.col_inputs = pat[k];
      bus.start      = (k == start_at);
      model_row(pat[k]);
      tick();
    end
    bus.start      = 1'b0;
    bus.col_inputs = '0;
    check("end_done", bus.done, 1);
    check("end_busy", bus.busy, 0);
    check("end_row_idx", bus.row_idx, 0);
  endtask

  task automatic set_pat(input logic [7:0] v);
    foreach (pat[k]) pat[k] = v;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.col_inputs = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    // idle: faults on the inputs without start are ignored
    bus.col_inputs = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_row_idx", bus.row_idx, 0);
      check("idle_busy", bus.busy, 0);
    end
    check_all_zero("idle");
    bus.col_inputs = '0;

    // clean pass
    set_pat(8'h00);
    scan_pass(-1);
    check("clean_rmap", bus.row_fault_detection, 0);
    check("clean_cmap", bus.column_fault_detection, 0);
    check("clean_fc", bus.fault_count, 0);

    // row detection: three isolated faults in row 2
    set_pat(8'h00);
    pat[2] = 8'b1010_1000;
    scan_pass(-1);
`ifdef DIAG_CONSECUTIVE_EN
    check("rowdet_rmap", bus.row_fault_detection, 8'h00);
`else
    check("rowdet_rmap", bus.row_fault_detection, 8'h04);
`endif
    check("rowdet_fc", bus.fault_count, 3);
    tick();
    check("done_hold", bus.done, 1);
    check("done_hold_fc", bus.fault_count, 3);

    // column detection, non-adjacent rows (restart from DONE)
    set_pat(8'h00);
    pat[1] = 8'h20;
    pat[3] = 8'h20;
    pat[4] = 8'h20;
    scan_pass(-1);
`ifdef DIAG_CONSECUTIVE_EN
    check("coldet1_cmap", bus.column_fault_detection, 8'h00);
`else
    check("coldet1_cmap", bus.column_fault_detection, 8'h20);
`endif
    check("coldet1_rmap", bus.row_fault_detection, 8'h00);
    check("coldet1_fc", bus.fault_count, 3);

    // column detection, adjacent rows
    set_pat(8'h00);
    pat[2] = 8'h20;
    pat[3] = 8'h20;
    pat[4] = 8'h20;
    scan_pass(-1);
    check("coldet2_cmap", bus.column_fault_detection, 8'h20);
    check("coldet2_fc", bus.fault_count, 3);

    // saturation, with a stray start mid-pass that must be ignored
    set_pat(8'hFF);
    scan_pass(4);
    check("sat_fc", bus.fault_count, 64);
    check("sat_rmap", bus.row_fault_detection, 8'hFF);
    check("sat_cmap", bus.column_fault_detection, 8'hFF);

    // abort at row_idx 3, together with start (abort wins)
    model_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.col_inputs = (k < 2) ? 8'hFF : 8'h00;
      model_row(bus.col_inputs);
      tick();
    end
    check("abort_at_row_idx", bus.row_idx, 3);
    bus.abort      = 1'b1;
    bus.start      = 1'b1;
    bus.col_inputs = 8'hFF;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_row_idx", bus.row_idx, 0);
    check("abort_valid", bus.single_pe_valid, 0);
    check("abort_rmap", bus.row_fault_detection, 8'h03);
    check("abort_cmap", bus.column_fault_detection, 8'h00);
    check("abort_fc", bus.fault_count, 16);
    for (int i = 0; i < 3; i++) tick();
    check("abort_hold_fc", bus.fault_count, 16);
    check("abort_hold_busy", bus.busy, 0);
    check("abort_hold_done", bus.done, 0);
    bus.col_inputs = '0;

    // asynchronous reset mid-pass at row_idx 5
    model_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.col_inputs = 8'hFF;
      model_row(bus.col_inputs);
      tick();
    end
    check("rstmid_row_idx", bus.row_idx, 5);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid");
    bus.col_inputs = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
